div: RTL and testbench

- Multi-cycle radix-2 restoring divider for DIV/DIVU.
- Sits beside the execute stage and consumes its div_opdata1/div_opdata2/div_start/signed_div outputs.
- Returns {remainder, quotient} plus a ready flag to that stage, which writes the result to HI/LO.
- Execute holds start high (and stalls the pipeline) until ready is seen.

---
 rtl/div.sv | 145 ++++++++++++++
 tb/tb_div.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
// Optional fast divide-by-zero path enabled by defining DIV_BYZERO_FAST_EN.
module div #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   localparam int CW = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]   dvd_q, dvd_d;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic                sgn_q, sgn_d;
   logic                s1_q, s1_d;
   logic                s2_q, s2_d;
   logic [2*DATA_W-1:0] result_q, result_d;
   logic                ready_q, ready_d;

   logic [DATA_W:0]     trial;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   // rem_q < dvs_q always holds, so {rem, next bit} fits in DATA_W+1 bits
   assign trial   = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dvs_q};
   assign quo_fix = (sgn_q && (s1_q ^ s2_q)) ? '0 - dvd_q : dvd_q;
   assign rem_fix = (sgn_q && s1_q) ? '0 - rem_q : rem_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      sgn_d    = sgn_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      result_d = result_q;
      ready_d  = ready_q;
      case (state_q)
         FREE: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (start_i && !annul_i) begin
               sgn_d   = signed_div_i;
               s1_d    = opdata1_i[DATA_W-1];
               s2_d    = opdata2_i[DATA_W-1];
               dvd_d   = (signed_div_i && opdata1_i[DATA_W-1]) ? '0 - opdata1_i : opdata1_i;
               dvs_d   = (signed_div_i && opdata2_i[DATA_W-1]) ? '0 - opdata2_i : opdata2_i;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = ON;
`ifdef DIV_BYZERO_FAST_EN
               if (opdata2_i == '0) state_d = BYZERO;
`endif
            end
         end
`ifdef DIV_BYZERO_FAST_EN
         BYZERO: begin
            if (annul_i) begin
               state_d = FREE;
            end else begin
               state_d  = END;
               result_d = '0;
               ready_d  = 1'b1;
            end
         end
`endif
         ON: begin
            if (annul_i) begin
               state_d  = FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end else if (cnt_q == CW'(DATA_W)) begin
               // all iterations done: apply sign correction and present the result
               state_d  = END;
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (!trial[DATA_W]) begin
                  rem_d = trial[DATA_W-1:0];
                  dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
               end else begin
                  rem_d = {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
                  dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
               end
            end
         end
         END: begin
            if (!start_i || annul_i) begin
               state_d  = FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
         default: begin
            state_d  = FREE;
            result_d = '0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FREE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         sgn_q    <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         sgn_q    <= sgn_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: vector table plus abort, reset, start-drop and hold sequences.
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        sgn;
   logic [31:0] op1, op2;
   logic        start, annul;
   logic [63:0] result;
   logic        ready;

   int total = 0;
   int bad   = 0;

   div #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
      .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] expv;
      int          lat;
   } vec_t;

`ifdef DIV_BYZERO_FAST_EN
   localparam int          LAT_BZ = 2;
   localparam logic [63:0] R_U5_0 = 64'h0;
   localparam logic [63:0] R_SN5_0 = 64'h0;
`else
   localparam int          LAT_BZ = 34;
   localparam logic [63:0] R_U5_0 = 64'h00000005_FFFFFFFF;
   localparam logic [63:0] R_SN5_0 = 64'hFFFFFFFB_00000001;
`endif

   vec_t vt[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   // Called at a negedge; drives a request and holds start until ready or timeout.
   task automatic run_op(input vec_t v, input int hold, input string nm);
      int cyc = 0;
      sgn = v.sgn; op1 = v.a; op2 = v.b; start = 1'b1;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 1) begin
            op1 = $urandom; op2 = $urandom; sgn = ~sgn;
         end
      end while (!ready && cyc < 100);
      chk({nm, "_lat"}, 64'(cyc), 64'(v.lat));
      chk({nm, "_res"}, result, v.expv);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk({nm, "_hold_rdy"}, 64'(ready), 64'd1);
         chk({nm, "_hold_res"}, result, v.expv);
      end
      start = 1'b0;
      @(negedge clk);
      chk({nm, "_drop_rdy"}, 64'(ready), 64'd0);
      chk({nm, "_drop_res"}, result, 64'd0);
   endtask

   initial begin
      int   nrdy;
      logic [63:0] cap;
      vec_t v;

      vt[0] = '{1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 34};
      vt[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34};
      vt[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34};
      vt[3] = '{1'b0, 32'hFFFFFFFF, 32'h10,       64'h0000000F_0FFFFFFF, 34};
      vt[4] = '{1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 34};
      vt[5] = '{1'b0, 32'd5,        32'd0,        R_U5_0,                LAT_BZ};
      vt[6] = '{1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34};
      vt[7] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 34};
      vt[8] = '{1'b1, 32'hFFFFFFFB, 32'd0,        R_SN5_0,               LAT_BZ};
      vt[9] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34};

      rst = 1'b1; sgn = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
      #1;
      chk("reset_rdy", 64'(ready), 64'd0);
      chk("reset_res", result, 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_op(vt[i], (i == 0) ? 3 : 0, $sformatf("vec%0d", i));
         @(negedge clk);
      end

      // abort after 10 iterations, then a new request right behind it
      sgn = 1'b0; op1 = 32'd7; op2 = 32'd2; start = 1'b1;
      nrdy = 0;
      repeat (11) begin
         @(negedge clk);
         if (ready) nrdy++;
      end
      annul = 1'b1;
      @(negedge clk);
      if (ready) nrdy++;
      annul = 1'b0;
      chk("abort_rdy", 64'(nrdy), 64'd0);
      run_op(vt[4], 0, "after_abort");
      @(negedge clk);

      // start dropped mid-run: ready pulses exactly once
      sgn = 1'b0; op1 = 32'd7; op2 = 32'd2; start = 1'b1;
      repeat (5) @(negedge clk);
      start = 1'b0;
      nrdy = 0; cap = '0;
      repeat (40) begin
         @(negedge clk);
         if (ready) begin nrdy++; cap = result; end
      end
      chk("drop_pulse_cnt", 64'(nrdy), 64'd1);
      chk("drop_pulse_res", cap, 64'h00000001_00000003);

      // annul together with start in FREE: nothing starts
      start = 1'b1; annul = 1'b1;
      nrdy = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) nrdy++;
      end
      chk("free_annul", 64'(nrdy), 64'd0);
      start = 1'b0; annul = 1'b0;
      @(negedge clk);

      // annul while in END
      sgn = 1'b0; op1 = 32'd7; op2 = 32'd2; start = 1'b1;
      repeat (34) @(negedge clk);
      chk("end_pre_rdy", 64'(ready), 64'd1);
      annul = 1'b1;
      @(negedge clk);
      chk("end_annul_rdy", 64'(ready), 64'd0);
      chk("end_annul_res", result, 64'd0);
      annul = 1'b0; start = 1'b0;
      @(negedge clk);

      // async reset mid-iteration, then a clean run
      start = 1'b1;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_on_rdy", 64'(ready), 64'd0);
      chk("rst_on_res", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(vt[1], 0, "after_rst");
      @(negedge clk);

      // async reset while result is held, between clock edges
      v = vt[3];
      sgn = v.sgn; op1 = v.a; op2 = v.b; start = 1'b1;
      repeat (34) @(negedge clk);
      chk("rst_end_pre", result, v.expv);
      #2 rst = 1'b1;
      #1;
      chk("rst_end_rdy", 64'(ready), 64'd0);
      chk("rst_end_res", result, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
